// File: rtl/ctrl_seg_fifo.sv
// Control-word pipeline segment: small circular FIFO with bubble hold, flush and a
// saturating stall counter. Storage is not reset; an empty FIFO always shows FLUSH_VAL.
module ctrl_seg_fifo #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  FLUSH_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bubble_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             push, pop;

  assign in_ready_o  = (occ_q < OccFull) && !bubble_i;
  assign out_valid_o = (occ_q != '0) && !bubble_i;
  assign out_data_o  = (occ_q != '0) ? mem_q[rd_ptr_q] : FLUSH_VAL;
  assign occupancy_o = occ_q;
  assign stall_cnt_o = stall_cnt_q;

  // in_ready/out_valid already carry !bubble, so bubble also blocks push and pop.
  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    stall_cnt_d = stall_cnt_q;
    if (bubble_i) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        occ_d = occ_q + 1'b1;
      end else if (pop && !push) begin
        occ_d = occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_ctrl_seg_fifo.sv
// Directed bench for ctrl_seg_fifo (WIDTH=8, DEPTH=2) plus a CNT_W=2 instance
// for stall counter saturation.
module tb_ctrl_seg_fifo;

  logic       clk = 1'b0;
  logic       rst, bubble, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [15:0] stall_cnt;

  logic       rst_s, bubble_s;
  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [1:0] s_occupancy;
  logic [1:0] s_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_seg_fifo #(
    .WIDTH(8), .DEPTH(2), .FLUSH_VAL(8'h00), .CNT_W(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .bubble_i(bubble), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .occupancy_o(occupancy), .stall_cnt_o(stall_cnt)
  );

  ctrl_seg_fifo #(
    .WIDTH(8), .DEPTH(2), .FLUSH_VAL(8'h00), .CNT_W(2)
  ) u_sat (
    .clk_i(clk), .rst_i(rst_s), .bubble_i(bubble_s), .flush_i(1'b0),
    .in_valid_i(1'b0), .in_ready_o(s_in_ready), .in_data_i(8'h00),
    .out_valid_o(s_out_valid), .out_ready_i(1'b0), .out_data_o(s_out_data),
    .occupancy_o(s_occupancy), .stall_cnt_o(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_s = 1'b1;
    bubble = 1'b0; bubble_s = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    tick();
    rst = 1'b0; rst_s = 1'b0;

    // Basic pass, one-cycle latency
    in_valid = 1'b1; in_data = 8'hA5;
    #1 chk("pass_pre_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("pass_valid", out_valid, 1);
    chk("pass_data", out_data, 8'hA5);
    chk("pass_occ", occupancy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pass_drain_occ", occupancy, 0);
    chk("pass_drain_data", out_data, 8'h00);
    chk("pass_drain_valid", out_valid, 0);

    // Full: third word refused even with a same-cycle pop
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    chk("full_occ", occupancy, 2);
    in_data = 8'h33; out_ready = 1'b1;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_head0", out_data, 8'h11);
    tick();
    in_valid = 1'b0;
    chk("full_head1", out_data, 8'h22);
    chk("full_no_33_occ", occupancy, 1);
    tick();
    out_ready = 1'b0;
    chk("full_empty_data", out_data, 8'h00);
    chk("full_empty_occ", occupancy, 0);

    // Bubble beats flush
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    bubble = 1'b1; flush = 1'b1;
    #1;
    chk("bub_out_valid", out_valid, 0);
    chk("bub_in_ready", in_ready, 0);
    chk("bub_data_visible", out_data, 8'h11);
    tick(); tick(); tick();
    chk("bub_occ", occupancy, 2);
    chk("bub_stall", stall_cnt, 3);
    bubble = 1'b0; flush = 1'b0;
    #1;
    chk("bub_after_data", out_data, 8'h11);
    chk("bub_after_valid", out_valid, 1);
    tick();
    chk("bub_hold_occ", occupancy, 2);

    // Flush drops a same-cycle push
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("flush_pre_occ", occupancy, 1);
    chk("flush_pre_data", out_data, 8'h22);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_data", out_data, 8'h00);
    chk("flush_valid", out_valid, 0);
    tick();
    chk("flush_44_dropped", occupancy, 0);
    chk("flush_keeps_stall", stall_cnt, 3);

    // Streaming push+pop with pointer wrap
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h01;
    tick();
    chk("wrap_first", out_data, 8'h01);
    for (int k = 2; k <= 6; k++) begin
      in_data = 8'(k);
      tick();
      chk($sformatf("wrap_data%0d", k), out_data, 64'(k));
      chk($sformatf("wrap_occ%0d", k), occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("wrap_end_occ", occupancy, 0);
    chk("wrap_end_data", out_data, 8'h00);

    // Asynchronous reset between edges
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_data = 8'hBB;
    tick();
    in_valid = 1'b0;
    chk("arst_pre_occ", occupancy, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_data", out_data, 8'h00);
    chk("arst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'hCC;
    tick();
    in_valid = 1'b0;
    chk("arst_first_push", out_data, 8'hCC);
    chk("arst_first_occ", occupancy, 1);

    // Saturation with CNT_W=2
    bubble_s = 1'b1;
    tick(); tick();
    chk("sat_two", s_stall_cnt, 2);
    tick(); tick(); tick();
    bubble_s = 1'b0;
    chk("sat_five", s_stall_cnt, 3);
    tick();
    chk("sat_hold", s_stall_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_seg_fifo.md
CTRL_SEG_FIFO -- requirements
Module: ctrl_seg_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk rising edge; rst asynchronous, active-high.
REQ-002 The block SHALL provide parameter WIDTH, default 16, control-word width in bits (1..64).
REQ-003 The block SHALL provide parameter DEPTH, default 2, number of entries (1..8, any integer).
REQ-004 The block SHALL provide parameter FLUSH_VAL, default 0, WIDTH-bit value presented on out_data when empty.
REQ-005 The block SHALL provide parameter CNT_W, default 16, width of stall_cnt.
REQ-006 The block SHALL have port clk, input, 1, clock.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port bubble, input, 1, stage hold: no push, pop or flush this cycle.
REQ-009 The block SHALL have port flush, input, 1, discard all stored entries.
REQ-010 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, WIDTH), forming the upstream handshake.
REQ-011 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, WIDTH), forming the downstream handshake.
REQ-012 The block SHALL have port occupancy, output, $clog2(DEPTH+1), stored entry count.
REQ-013 The block SHALL have port stall_cnt, output, CNT_W, saturating count of bubble cycles.

Function
REQ-014 The block SHALL store entries in a circular buffer with rd_ptr and wr_ptr, each wrapping from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
REQ-015 in_ready SHALL equal (occupancy < DEPTH) && !bubble, combinationally; there SHALL be no pass-through when full, even if a pop occurs in the same cycle.
REQ-016 out_valid SHALL equal (occupancy != 0) && !bubble.
REQ-017 out_data SHALL show the head entry when occupancy != 0, and FLUSH_VAL otherwise, with no dependence on bubble.
REQ-018 A push SHALL occur when in_valid && in_ready && !flush; in_data is written at wr_ptr and wr_ptr advances.
REQ-019 A pop SHALL occur when out_valid && out_ready && !flush; rd_ptr advances.
REQ-020 A simultaneous push and pop SHALL leave occupancy unchanged and advance both pointers.
REQ-021 Latency SHALL be one cycle: data pushed into an empty block appears on out_data, with out_valid=1, on the next edge.
REQ-022 Priority SHALL be bubble > flush > push/pop: while bubble=1, all state except stall_cnt holds, and flush is ignored (not latched).
REQ-023 A flush with bubble=0 SHALL set occupancy to 0 and rd_ptr = wr_ptr = 0 on the next edge, dropping any same-cycle push or pop.
REQ-024 stall_cnt SHALL increment on each edge with bubble=1, and saturate at 2^CNT_W-1 (no wrap); flush does not clear it.
REQ-025 Writes to a full block and reads from an empty block SHALL be impossible by REQ-015/016; stored entries SHALL be unchanged when no push occurs.

Reset
REQ-026 When rst=1, the block SHALL immediately, without waiting for clk, set occupancy=0, rd_ptr=wr_ptr=0 and stall_cnt=0, giving out_valid=0, out_data=FLUSH_VAL and in_ready=1 (if bubble=0).
REQ-027 A reset mid-operation SHALL discard all entries; storage contents need not be cleared, but SHALL never be visible while empty.
REQ-028 The first push SHALL be accepted on the first rising clk edge after rst deasserts.

Verification (WIDTH=8, DEPTH=2, FLUSH_VAL=8'h00)
REQ-029 The bench SHALL cover the basic pass: push 8'hA5 with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, occupancy=1.
REQ-030 The bench SHALL cover full: push 8'h11 then 8'h22, then offer 8'h33 -> in_ready=0, 8'h33 is not stored; popping gives 8'h11 then 8'h22, then out_data=8'h00.
REQ-031 The bench SHALL cover bubble over flush: occupancy=2, bubble=1 and flush=1 for 3 cycles -> occupancy stays 2, stall_cnt=3, out_valid=0; after bubble=0 with no flush, out_data=8'h11.
REQ-032 The bench SHALL cover flush plus push: occupancy=1, flush=1, in_valid=1 with 8'h44 -> next cycle occupancy=0, out_data=8'h00, and 8'h44 is dropped.
REQ-033 The bench SHALL cover wrap and simultaneous operation: 6 cycles with continuous push and pop of 8'h01..8'h06 -> outputs arrive in order, one cycle late, occupancy constant at 1, and the pointers wrap correctly.
REQ-034 The bench SHALL cover async reset: assert rst between edges while occupancy=2 -> out_valid=0, occupancy=0 and stall_cnt=0 immediately; with CNT_W=2 and 5 bubble cycles, stall_cnt=3.
